// File: rtl/fm_sb_pkg.sv
// Shared types and constants for the spy-buffer freeze/readout scheduler.
package fm_sb_pkg;

    // Scheduler FSM states. The numeric values are visible on the state output.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_POST   = 3'd2,
        ST_FREEZE = 3'd3,
        ST_DONE   = 3'd4
    } fm_sched_state_t;

    // Trigger source selection encodings.
    localparam logic [1:0] TRIG_SEL_SW  = 2'd0;
    localparam logic [1:0] TRIG_SEL_HW  = 2'd1;
    localparam logic [1:0] TRIG_SEL_ANY = 2'd2;
    localparam logic [1:0] TRIG_SEL_OFF = 2'd3;

endpackage

// File: rtl/fm_sb_next_idx.sv
// Combinational search for the next enabled spy-buffer index above cur_idx.
// With from_start set the search begins below index 0, so bit 0 is eligible.
module fm_sb_next_idx
    import fm_sb_pkg::*;
#(
    parameter int SB_N  = 27,
    parameter int IDX_W = $clog2(SB_N)
) (
    input  logic [SB_N-1:0]  mask,
    input  logic [IDX_W-1:0] cur_idx,
    input  logic             from_start,
    output logic [IDX_W-1:0] next_idx,
    output logic             none
);

    logic [SB_N-1:0] cand;

    // A bit is a candidate when it is enabled and lies strictly above cur_idx.
    generate
        for (genvar gi = 0; gi < SB_N; gi++) begin : g_cand
            assign cand[gi] = mask[gi] & (from_start | (IDX_W'(gi) > cur_idx));
        end
    endgenerate

    // Lowest candidate wins: scanning downwards lets the last hit be the smallest.
    always_comb begin
        next_idx = '0;
        none     = 1'b1;
        for (int i = SB_N - 1; i >= 0; i--) begin
            if (cand[i]) begin
                next_idx = IDX_W'(i);
                none     = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fm_freeze_sched.sv
// Freeze/readout scheduler for the fast-monitoring spy buffers.
// Arms on command, waits a post-trigger window after the selected trigger,
// freezes the enabled buffers together, then hands them one at a time to the
// readout engine and keeps them frozen until released.
module fm_freeze_sched
    import fm_sb_pkg::*;
#(
    parameter int SB_N  = 27,
    parameter int CNT_W = 16,
    parameter int IDX_W = $clog2(SB_N)
) (
    input  logic             clk_hs,
    input  logic             rst_hs,
    input  logic [SB_N-1:0]  sb_enable,
    input  logic             arm,
    input  logic             sw_trigger,
    input  logic             hw_trigger,
    input  logic [1:0]       trig_sel,
    input  logic [CNT_W-1:0] post_trig_len,
    input  logic             release_pulse,
    input  logic             rd_ack,
    output logic [SB_N-1:0]  freeze,
    output logic             rd_req,
    output logic [IDX_W-1:0] rd_idx,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] trig_count
);

    fm_sched_state_t  state_reg;
    logic [SB_N-1:0]  mask_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             hw_prev_reg;
    logic             first_reg;     // next grant searches from below index 0
    logic [SB_N-1:0]  freeze_reg;
    logic             rd_req_reg;
    logic [IDX_W-1:0] rd_idx_reg;
    logic [CNT_W-1:0] trig_count_reg;

    logic             hw_rise;
    logic             trig_hit;
    logic [IDX_W-1:0] next_idx;
    logic             next_none;

    assign hw_rise = hw_trigger & ~hw_prev_reg;

    // Qualify the raw trigger sources according to the selected mode.
    always_comb begin
        trig_hit = 1'b0;
        case (trig_sel)
            TRIG_SEL_SW:  trig_hit = sw_trigger;
            TRIG_SEL_HW:  trig_hit = hw_rise;
            TRIG_SEL_ANY: trig_hit = sw_trigger | hw_rise;
            default:      trig_hit = 1'b0;
        endcase
    end

    // One search unit serves both the first grant and every later grant, and
    // also tells the ack cycle whether the walk is finished.
    fm_sb_next_idx #(
        .SB_N  (SB_N),
        .IDX_W (IDX_W)
    ) u_next_idx (
        .mask       (mask_reg),
        .cur_idx    (rd_idx_reg),
        .from_start (first_reg),
        .next_idx   (next_idx),
        .none       (next_none)
    );

    // Scheduler FSM; release overrides every other event in every state.
    always_ff @(posedge clk_hs) begin
        if (rst_hs) begin
            state_reg      <= ST_IDLE;
            mask_reg       <= '0;
            cnt_reg        <= '0;
            hw_prev_reg    <= 1'b0;
            first_reg      <= 1'b0;
            freeze_reg     <= '0;
            rd_req_reg     <= 1'b0;
            rd_idx_reg     <= '0;
            trig_count_reg <= '0;
        end else begin
            hw_prev_reg <= hw_trigger;
            if (release_pulse) begin
                state_reg  <= ST_IDLE;
                cnt_reg    <= '0;
                first_reg  <= 1'b0;
                freeze_reg <= '0;
                rd_req_reg <= 1'b0;
                rd_idx_reg <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (arm) begin
                            state_reg <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (trig_hit) begin
                            mask_reg <= sb_enable;
                            cnt_reg  <= post_trig_len;
                            if (trig_count_reg != '1) begin
                                trig_count_reg <= trig_count_reg + CNT_W'(1);
                            end
                            // A zero-length window freezes on the cycle after accept.
                            if (post_trig_len == '0) begin
                                if (sb_enable == '0) begin
                                    state_reg <= ST_DONE;
                                end else begin
                                    state_reg  <= ST_FREEZE;
                                    freeze_reg <= sb_enable;
                                    first_reg  <= 1'b1;
                                end
                            end else begin
                                state_reg <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        // Window expires as the count reaches zero, so freeze
                        // lands exactly post_trig_len cycles after entering POST.
                        cnt_reg <= (cnt_reg == '0) ? '0 : cnt_reg - CNT_W'(1);
                        if ((cnt_reg == CNT_W'(1)) || (cnt_reg == '0)) begin
                            if (mask_reg == '0) begin
                                state_reg <= ST_DONE;
                            end else begin
                                state_reg  <= ST_FREEZE;
                                freeze_reg <= mask_reg;
                                first_reg  <= 1'b1;
                            end
                        end
                    end
                    ST_FREEZE: begin
                        if (rd_req_reg) begin
                            if (rd_ack) begin
                                rd_req_reg <= 1'b0;
                                if (next_none) begin
                                    state_reg <= ST_DONE;
                                end
                            end
                        end else begin
                            // Entry cycle or the one-cycle gap after an ack.
                            rd_req_reg <= 1'b1;
                            rd_idx_reg <= next_idx;
                            first_reg  <= 1'b0;
                        end
                    end
                    ST_DONE: begin
                        state_reg <= ST_DONE;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign freeze     = freeze_reg;
    assign rd_req     = rd_req_reg;
    assign rd_idx     = rd_idx_reg;
    assign state      = state_reg;
    assign trig_count = trig_count_reg;

endmodule
